// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding and transition function, command codes,
// and the standard IR opcodes of the target.
package jtag_pkg;

  typedef enum logic [3:0] {
    TestLogicReset,
    RunTestIdle,
    SelectDrScan,
    CaptureDr,
    ShiftDr,
    Exit1Dr,
    PauseDr,
    Exit2Dr,
    UpdateDr,
    SelectIrScan,
    CaptureIr,
    ShiftIr,
    Exit1Ir,
    PauseIr,
    Exit2Ir,
    UpdateIr
  } tap_state_t;

  localparam logic [1:0] CMD_TLR  = 2'd0;
  localparam logic [1:0] CMD_IR   = 2'd1;
  localparam logic [1:0] CMD_DR   = 2'd2;
  localparam logic [1:0] CMD_IDLE = 2'd3;

  localparam logic [3:0] IDCODE   = 4'h7;
  localparam logic [3:0] BYPASS   = 4'hF;
  localparam logic [3:0] SAMPLE   = 4'h1;
  localparam logic [3:0] EXTEST   = 4'h2;
  localparam logic [3:0] INTEST   = 4'h3;
  localparam logic [3:0] USERCODE = 4'h8;
  localparam logic [3:0] RUNBIST  = 4'h4;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    case (s)
      TestLogicReset: n = tms ? TestLogicReset : RunTestIdle;
      RunTestIdle:    n = tms ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   n = tms ? SelectIrScan   : CaptureDr;
      CaptureDr:      n = tms ? Exit1Dr        : ShiftDr;
      ShiftDr:        n = tms ? Exit1Dr        : ShiftDr;
      Exit1Dr:        n = tms ? UpdateDr       : PauseDr;
      PauseDr:        n = tms ? Exit2Dr        : PauseDr;
      Exit2Dr:        n = tms ? UpdateDr       : ShiftDr;
      UpdateDr:       n = tms ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   n = tms ? TestLogicReset : CaptureIr;
      CaptureIr:      n = tms ? Exit1Ir        : ShiftIr;
      ShiftIr:        n = tms ? Exit1Ir        : ShiftIr;
      Exit1Ir:        n = tms ? UpdateIr       : PauseIr;
      PauseIr:        n = tms ? Exit2Ir        : PauseIr;
      Exit2Ir:        n = tms ? UpdateIr       : ShiftIr;
      UpdateIr:       n = tms ? SelectDrScan   : RunTestIdle;
      default:        n = TestLogicReset;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK generator: low phase first, CLK_DIV clk per half-period. The strobes flag the clk
// edge on which TCK falls (or a low phase starts) and the edge on which it rises.
module jtag_tck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tck,
  output logic fall_stb,
  output logic rise_stb
);
  localparam int CNT_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tck_q, tck_d;

  assign fall_stb = en && (cnt_q == '0);
  assign rise_stb = en && (cnt_q == CNT_W'(CLK_DIV));
  assign tck      = tck_q;

  always_comb begin
    cnt_d = '0;
    tck_d = 1'b0;
    if (en) begin
      cnt_d = (cnt_q == CNT_W'(2 * CLK_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
      tck_d = tck_q;
      if (fall_stb) tck_d = 1'b0;
      if (rise_stb) tck_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

endmodule

// File: rtl/jtag_master.sv
// Host-side JTAG master: runs TLR/IR/DR/idle commands against a target TAP, tracking the
// target state in a shadow TAP and returning the TDO bits captured in Shift-xR.
module jtag_master
  import jtag_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int CLK_DIV = 4,
  localparam int LEN_W = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);
  // Counter must also hold the 6-TCK TLR segment for tiny MAX_LEN.
  localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;

  localparam logic [2:0] ST_INIT_TLR = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_NAV_IN   = 3'd2;
  localparam logic [2:0] ST_SHIFT    = 3'd3;
  localparam logic [2:0] ST_NAV_OUT  = 3'd4;
  localparam logic [2:0] ST_RUN      = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ir_q, ir_d;
  logic               cmd_act_q, cmd_act_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               rsp_valid_q, rsp_valid_d;
  tap_state_t         tap_q, tap_d;

  logic               busy, fall_stb, rise_stb;
  logic [LEN_W-1:0]   len_eff;
  logic [CNT_W-1:0]   seg_len, drv_idx, cnt_m1;
  logic [2:0]         drv_st;
  logic               finish;

  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign len_eff   = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
  assign cnt_m1    = cnt_q - CNT_W'(1);
  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = cap_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;

  jtag_tck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tck_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (busy),
    .tck     (TCK),
    .fall_stb(fall_stb),
    .rise_stb(rise_stb)
  );

  // Number of TCKs in the current segment of the scan.
  always_comb begin
    case (state_q)
      ST_INIT_TLR: seg_len = CNT_W'(6);
      ST_NAV_IN:   seg_len = ir_q ? CNT_W'(4) : CNT_W'(3);
      ST_SHIFT:    seg_len = CNT_W'(len_q);
      ST_NAV_OUT:  seg_len = CNT_W'(2);
      ST_RUN:      seg_len = CNT_W'(len_q);
      default:     seg_len = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    ir_d        = ir_q;
    cmd_act_d   = cmd_act_q;
    data_d      = data_q;
    cap_d       = cap_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    rsp_valid_d = 1'b0;
    tap_d       = tap_q;
    drv_st      = state_q;
    drv_idx     = cnt_q;
    finish      = 1'b0;

    // Segment exhausted: the next TCK belongs to the following segment, or the command ends.
    if (cnt_q == seg_len) begin
      drv_idx = '0;
      case (state_q)
        ST_NAV_IN: drv_st = ST_SHIFT;
        ST_SHIFT:  drv_st = ST_NAV_OUT;
        default:   finish = 1'b1;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          len_d     = len_eff;
          ir_d      = (cmd_type == CMD_IR);
          cmd_act_d = 1'b1;
          data_d    = cmd_data;
          cap_d     = '0;
          cnt_d     = '0;
          if (cmd_type == CMD_TLR)       state_d = ST_INIT_TLR;
          else if (len_eff == '0)        state_d = ST_DONE;
          else if (cmd_type == CMD_IDLE) state_d = ST_RUN;
          else                           state_d = ST_NAV_IN;
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
      end
      default: begin
        if (fall_stb) begin
          tdi_d = 1'b0;
          if (finish) begin
            state_d     = ST_IDLE;
            rsp_valid_d = cmd_act_q;
            tms_d       = 1'b0;
          end else begin
            state_d = drv_st;
            cnt_d   = drv_idx + CNT_W'(1);
            case (drv_st)
              ST_INIT_TLR: tms_d = (drv_idx < CNT_W'(5));
              ST_NAV_IN:   tms_d = (drv_idx == '0) || (ir_q && (drv_idx == CNT_W'(1)));
              ST_SHIFT: begin
                tms_d = (drv_idx == CNT_W'(len_q) - CNT_W'(1));
                tdi_d = |(data_q & (MAX_LEN'(1) << drv_idx));
              end
              ST_NAV_OUT:  tms_d = (drv_idx == '0);
              default:     tms_d = 1'b0;
            endcase
          end
        end
      end
    endcase

    if (rise_stb) begin
      tap_d = tap_next(tap_q, tms_q);
      if ((state_q == ST_SHIFT) && ((tap_q == ShiftDr) || (tap_q == ShiftIr))) begin
        cap_d = cap_q | (MAX_LEN'(TDO) << cnt_m1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT_TLR;
      cnt_q       <= '0;
      len_q       <= '0;
      ir_q        <= 1'b0;
      cmd_act_q   <= 1'b0;
      data_q      <= '0;
      cap_q       <= '0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      tap_q       <= TestLogicReset;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      ir_q        <= ir_d;
      cmd_act_q   <= cmd_act_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      rsp_valid_q <= rsp_valid_d;
      tap_q       <= tap_d;
    end
  end

endmodule
